// File: rtl/fsic_clock_phase_det.sv
// fsic_clock_phase_det
//   Receive-side checker for the divided clock produced by the far-end
//   io_serdes fast-to-core divider. It samples div_clk_in with the local fast
//   clock and checks that the period is DIV cycles. It reports lock, the
//   captured phase and period errors. While locked it also drives a locally
//   regenerated divided clock that is aligned to the received one.
//
// Ports
//   clk         fast sampling clock, all logic on posedge
//   resetb      asynchronous active-low reset
//   enable      detector enable (level)
//   div_clk_in  received divided clock, asynchronous in phase
//   locked      high while the detector is in LOCKED
//   phase       free-running phase counter value at the last accepted edge
//   edge_strobe one-cycle pulse per synchronized rising edge
//   period_err  one-cycle pulse per bad edge or timeout
//   err_cnt     saturating count of period_err pulses (cleared by reset only)
//   clk_regen   regenerated divided clock, straight from a flop
module fsic_clock_phase_det #(
  parameter int DIV         = 4,
  parameter int PW          = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 8,
  parameter int LOSS_CNT    = 2
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          enable,
  input  logic          div_clk_in,
  output logic          locked,
  output logic [PW-1:0] phase,
  output logic          edge_strobe,
  output logic          period_err,
  output logic [7:0]    err_cnt,
  output logic          clk_regen
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOCKING,
    ST_LOCKED
  } state_t;

  localparam logic [PW-1:0] PH_MAX = PW'(DIV - 1);
  localparam logic [7:0]    DIV_L  = 8'(DIV);
  localparam logic [7:0]    HALF_L = 8'(DIV / 2);
  localparam logic [7:0]    TMO_L  = 8'(2 * DIV);
  localparam logic [7:0]    LOCK_L = 8'(LOCK_CNT);
  localparam logic [3:0]    LOSS_L = 4'(LOSS_CNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;
  logic [PW-1:0]          ph_cnt_q, ph_cnt_d;
  logic [7:0]             ivl_q, ivl_d;
  state_t                 state_q;
  logic                   locked_q;
  logic [PW-1:0]          phase_q;
  logic [7:0]             good_q;
  logic [3:0]             bad_q;
  logic                   period_err_q;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   regen_q;

  logic good_edge;
  logic bad_edge;
  logic timeout;
  logic checking;
  logic err_raise;

  // Edge qualification against the interval counter. A timeout only counts
  // when no edge arrives in the same cycle.
  always_comb begin
    checking  = (state_q == ST_LOCKING) || (state_q == ST_LOCKED);
    good_edge = edge_q && (ivl_q == DIV_L);
    bad_edge  = edge_q && (ivl_q != DIV_L);
    timeout   = !edge_q && (ivl_q == TMO_L) && checking;
    err_raise = enable && checking && (bad_edge || timeout);

    ph_cnt_d  = (ph_cnt_q == PH_MAX) ? '0 : ph_cnt_q + PW'(1);
    if (edge_q) begin
      ivl_d = 8'd1;
    end else if (ivl_q == 8'hFF) begin
      ivl_d = ivl_q;
    end else begin
      ivl_d = ivl_q + 8'd1;
    end
    err_cnt_d = (err_raise && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // Synchronizer, history flop and the registered rising-edge strobe. The
  // phase counter runs regardless of state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      edge_q   <= 1'b0;
      ph_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      hist_q   <= sync_q[SYNC_STAGES-1];
      edge_q   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      ph_cnt_q <= ph_cnt_d;
    end
  end

  // Lock state machine with its counters and registered outputs. Entering
  // SEARCH clears the interval counter. This takes priority over the edge
  // reload, because the next SEARCH edge reloads the counter anyway.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      locked_q     <= 1'b0;
      phase_q      <= '0;
      good_q       <= 8'd0;
      bad_q        <= 4'd0;
      ivl_q        <= 8'd0;
      period_err_q <= 1'b0;
      err_cnt_q    <= 8'd0;
      regen_q      <= 1'b1;
    end else begin
      ivl_q        <= ivl_d;
      period_err_q <= err_raise;
      err_cnt_q    <= err_cnt_d;

      // The regenerated clock rises on each accepted edge and falls halfway
      // through the period. It is parked high whenever the detector is not locked.
      if (state_q != ST_LOCKED) begin
        regen_q <= 1'b1;
      end else if (edge_q) begin
        regen_q <= 1'b1;
      end else if (ivl_q == HALF_L) begin
        regen_q <= 1'b0;
      end

      if (!enable) begin
        state_q  <= ST_IDLE;
        locked_q <= 1'b0;
        good_q   <= 8'd0;
        bad_q    <= 4'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SEARCH;
            ivl_q   <= 8'd0;
          end
          ST_SEARCH: begin
            if (edge_q) begin
              phase_q <= ph_cnt_q;
              good_q  <= 8'd0;
              state_q <= ST_LOCKING;
            end
          end
          ST_LOCKING: begin
            if (edge_q) begin
              phase_q <= ph_cnt_q;
              if (good_edge) begin
                good_q <= good_q + 8'd1;
                if (good_q + 8'd1 == LOCK_L) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                  bad_q    <= 4'd0;
                end
              end else begin
                good_q <= 8'd0;
              end
            end else if (timeout) begin
              state_q <= ST_SEARCH;
              good_q  <= 8'd0;
              ivl_q   <= 8'd0;
            end
          end
          ST_LOCKED: begin
            if (edge_q) begin
              if (good_edge) begin
                bad_q   <= 4'd0;
                phase_q <= ph_cnt_q;
              end else if (bad_q + 4'd1 == LOSS_L) begin
                state_q  <= ST_SEARCH;
                locked_q <= 1'b0;
                bad_q    <= 4'd0;
                ivl_q    <= 8'd0;
              end else begin
                bad_q <= bad_q + 4'd1;
              end
            end else if (timeout) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              bad_q    <= 4'd0;
              ivl_q    <= 8'd0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign locked      = locked_q;
  assign phase       = phase_q;
  assign edge_strobe = edge_q;
  assign period_err  = period_err_q;
  assign err_cnt     = err_cnt_q;
  assign clk_regen   = regen_q;

endmodule

// File: tb/tb_fsic_clock_phase_det.sv
// Testbench for fsic_clock_phase_det (DIV=4, PW=2, SYNC_STAGES=2,
// LOCK_CNT=8, LOSS_CNT=2).
// Each rising edge driven on div_clk_in pushes its expected response into a
// queue. A monitor pops one entry per response the DUT presents and compares
// it. A response is either an edge_strobe pulse, checked one cycle later, or
// a period_err pulse that arrives without an edge (a timeout).
module tb_fsic_clock_phase_det;

  logic       clk = 1'b0;
  logic       resetb;
  logic       enable;
  logic       divClkIn;
  logic       locked;
  logic [1:0] phase;
  logic       edgeStrobe;
  logic       periodErr;
  logic [7:0] errCnt;
  logic       clkRegen;

  fsic_clock_phase_det #(
    .DIV(4), .PW(2), .SYNC_STAGES(2), .LOCK_CNT(8), .LOSS_CNT(2)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .enable(enable),
    .div_clk_in(divClkIn),
    .locked(locked),
    .phase(phase),
    .edge_strobe(edgeStrobe),
    .period_err(periodErr),
    .err_cnt(errCnt),
    .clk_regen(clkRegen)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit isTimeout;
    bit expLocked;
    bit expPerr;
    int expErrCnt;
    int expPhase;
    bit expRegen;
  } rec_t;

  rec_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   modelErr    = 0;
  int   modelPhase  = 0;
  int   cyc;

  // Posedges since reset release. This tracks the DUT's free-running phase counter.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Called at a negedge. The rise is sampled at the next posedge, so the
  // edge is accepted three posedges later and captures phase (cyc+3) mod 4.
  task automatic applyStimulus(input int hi, input int lo, input bit expLocked,
                               input bit expErr, input bit capPhase,
                               input bit expRegen, input bit expTimeout);
    rec_t r;
    divClkIn = 1'b1;
    if (capPhase) modelPhase = (cyc + 3) % 4;
    if (expErr && modelErr < 255) modelErr++;
    r = '{1'b0, expLocked, expErr, modelErr, modelPhase, expRegen};
    expQ.push_back(r);
    if (expTimeout) begin
      if (modelErr < 255) modelErr++;
      r = '{1'b1, 1'b0, 1'b1, modelErr, modelPhase, 1'b1};
      expQ.push_back(r);
    end
    repeat (hi) @(negedge clk);
    divClkIn = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Drives a search edge, then 8 good edges (lock), then one more locked edge.
  task automatic relock();
    applyStimulus(2, 2, 0, 0, 1, 1, 0);
    repeat (7) applyStimulus(2, 2, 0, 0, 1, 1, 0);
    applyStimulus(2, 2, 1, 0, 1, 1, 0);
    applyStimulus(2, 2, 1, 0, 1, 0, 0);
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input bit isTimeout, input bit regenPre);
    rec_t r;
    bit   ok;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_event: kind=%0d with empty queue at t=%0t", isTimeout, $time);
      return;
    end
    r = expQ.pop_front();
    ok = (r.isTimeout == isTimeout) && (locked == r.expLocked) &&
         (periodErr == r.expPerr) && (int'(errCnt) == r.expErrCnt) &&
         (int'(phase) == r.expPhase) && (isTimeout || (regenPre == r.expRegen));
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL event%0d t=%0t (actual/expected): kind=%0d/%0d locked=%0d/%0d perr=%0d/%0d err_cnt=%0d/%0d phase=%0d/%0d regen=%0d/%0d",
               vectors, $time, isTimeout, r.isTimeout, locked, r.expLocked, periodErr, r.expPerr,
               errCnt, r.expErrCnt, phase, r.expPhase, regenPre, r.expRegen);
    end
  endtask

  // Monitor: clk_regen is taken in the strobe cycle, before the edge reloads it.
  // The remaining fields are taken one cycle later, after the edge has been accepted.
  initial begin
    bit regenPre;
    forever begin
      @(negedge clk);
      if (resetb && edgeStrobe) begin
        regenPre = clkRegen;
        @(negedge clk);
        checkOutput(1'b0, regenPre);
      end else if (resetb && periodErr) begin
        checkOutput(1'b1, 1'b1);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetb   = 1'b0;
    enable   = 1'b0;
    divClkIn = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("reset_locked", locked, 0);
    checkValue("reset_regen", clkRegen, 1);
    checkValue("reset_err_cnt", errCnt, 0);
    checkValue("reset_phase", phase, 0);
    checkValue("reset_strobe", edgeStrobe, 0);
    checkValue("reset_perr", periodErr, 0);
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    // IDLE: edges are still strobed, nothing else moves.
    repeat (3) applyStimulus(2, 2, 0, 0, 0, 1, 0);

    // Clean lock from an ideal div-4 input.
    enable = 1'b1;
    relock();
    applyStimulus(2, 2, 1, 0, 1, 0, 0);

    // Back to IDLE and re-enable, then a 3-cycle period after 5 good edges.
    enable = 1'b0;
    applyStimulus(2, 2, 0, 0, 0, 1, 0);
    enable = 1'b1;
    applyStimulus(2, 2, 0, 0, 1, 1, 0);
    repeat (4) applyStimulus(2, 2, 0, 0, 1, 1, 0);
    applyStimulus(2, 1, 0, 0, 1, 1, 0);
    applyStimulus(2, 2, 0, 1, 1, 1, 0);
    repeat (7) applyStimulus(2, 2, 0, 0, 1, 1, 0);
    applyStimulus(2, 2, 1, 0, 1, 1, 0);
    applyStimulus(2, 2, 1, 0, 1, 0, 0);

    // One 5-cycle period keeps lock; two in a row drop it.
    applyStimulus(2, 3, 1, 0, 1, 0, 0);
    applyStimulus(2, 2, 1, 1, 0, 0, 0);
    applyStimulus(2, 2, 1, 0, 1, 0, 0);
    applyStimulus(2, 3, 1, 0, 1, 0, 0);
    applyStimulus(2, 3, 1, 1, 0, 0, 0);
    applyStimulus(2, 2, 0, 1, 0, 0, 0);
    relock();

    // Input stuck low while locked: timeout, then relock.
    applyStimulus(2, 12, 1, 0, 1, 0, 1);
    relock();

    // Period-2 storm: lose lock, then a bad edge every 2 cycles in LOCKING.
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 1, 1, 1, 0);

    // Relock with err_cnt saturated, then reset asynchronously mid-cycle.
    applyStimulus(2, 2, 0, 1, 1, 1, 0);
    repeat (7) applyStimulus(2, 2, 0, 0, 1, 1, 0);
    applyStimulus(2, 2, 1, 0, 1, 1, 0);
    applyStimulus(2, 2, 1, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    checkValue("queue_drained", expQ.size(), 0);
    checkValue("sat_err_cnt", errCnt, 255);
    #2 resetb = 1'b0;
    #1;
    checkValue("async_locked", locked, 0);
    checkValue("async_regen", clkRegen, 1);
    checkValue("async_err_cnt", errCnt, 0);
    checkValue("async_phase", phase, 0);
    checkValue("async_perr", periodErr, 0);
    checkValue("async_strobe", edgeStrobe, 0);
    @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(negedge clk);
    checkValue("post_reset_locked", locked, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fsic_clock_phase_det.md
Name: fsic_clock_phase_det

Overview:
- Receive-side companion to the io_serdes fast-to-core clock divider.
- Samples a divided clock arriving from the far end (nominally fast/DIV) with the local fast clock and verifies its period.
- Reports lock, captured phase and period errors, and drives a locally regenerated divided clock aligned to the received one.
- Used by link bring-up logic to gate the serdes datapath until both ends agree on the divided-clock phase.

Parameters:
- DIV, 4: expected period of div_clk_in in clk cycles; must be even, 2..64.
- PW, 2: phase output width; must satisfy 2^PW >= DIV.
- SYNC_STAGES, 2: synchronizer flops on div_clk_in; 2..4.
- LOCK_CNT, 8: consecutive good edges required to lock; 1..255.
- LOSS_CNT, 2: consecutive bad edges in LOCKED that drop lock; 1..15.

Ports:
- clk  in  1  fast sampling clock; all logic on posedge.
- resetb  in  1  reset, asynchronous, active-low.
- enable  in  1  detector enable; level sensitive.
- div_clk_in  in  1  received divided clock; asynchronous to clk in phase.
- locked  out  1  high while state is LOCKED.
- phase  out  PW  value of ph_cnt captured at the last accepted edge.
- edge_strobe  out  1  one-cycle pulse per detected rising edge of the synchronized input.
- period_err  out  1  one-cycle pulse per bad edge or timeout.
- err_cnt  out  8  saturating count of period_err pulses.
- clk_regen  out  1  regenerated divided clock.

Behaviour:
Reset: while resetb=0, all outputs and internal state are cleared, except clk_regen, which is held at 1 (same reset polarity as the divider). State returns to IDLE.

Sync and edge detect:
- div_clk_in passes through SYNC_STAGES flops, then one history flop.
- edge_strobe is registered and equals (last sync stage=1 AND history=0).
- If div_clk_in is high with setup met at posedge n, edge_strobe is high in the cycle following posedge n+SYNC_STAGES.

Counters:
- ph_cnt: free-running 0..DIV-1, wraps to 0, runs in all states.
- ivl (8b):
  - Loads 1 at the posedge where edge_strobe=1 is sampled.
  - Otherwise increments, saturating at 255.
  - Cleared to 0 on entry to SEARCH.
  - A good edge has ivl==DIV when edge_strobe is sampled.

State machine (IDLE, SEARCH, LOCKING, LOCKED), with good_cnt (8b) and bad_cnt (4b):
- Any state, enable=0: go to IDLE next cycle; locked=0; good_cnt=0; bad_cnt=0. enable=0 has priority over every other event.
- IDLE, enable=1: go to SEARCH.
- SEARCH: the first edge captures phase<=ph_cnt and moves to LOCKING with good_cnt=0. No error is counted.
- LOCKING:
  - Good edge: good_cnt+1. When the incremented value equals LOCK_CNT, move to LOCKED; locked rises the following cycle.
  - Bad edge (ivl!=DIV): period_err, good_cnt=0, phase recaptured, stay in LOCKING.
- LOCKED:
  - Good edge: bad_cnt=0; phase recaptured (value unchanged in steady state).
  - Bad edge: period_err, bad_cnt+1. When it reaches LOSS_CNT, go to SEARCH with locked=0.
- Timeout in LOCKING or LOCKED: ivl reaches 2*DIV with no edge. Raise period_err and go to SEARCH immediately; locked=0 the next cycle.
- An edge sampled in the same cycle as a timeout counts as the edge; the timeout is ignored.

err_cnt: increments on each period_err and saturates at 255. It is cleared only by resetb.

clk_regen (flop):
- Outside LOCKED it is held at 1.
- In LOCKED:
  - Loads 1 at the posedge where edge_strobe is sampled.
  - Loads 0 at the posedge where ivl==DIV/2 is sampled (no edge that cycle).
  - Otherwise holds.
- Result: DIV/2 cycles high, DIV/2 cycles low, glitch-free. No combinational decode drives the output.

Reset mid-operation: takes effect immediately and asynchronously. On release, restart from IDLE; behaviour follows enable.

Test Plan:
- Reset and IDLE: resetb=0, then enable=0 with a toggling input -> locked=0, clk_regen=1, err_cnt=0; edge_strobe still pulses every 4 cycles.
- Clean lock (DIV=4, LOCK_CNT=8, SYNC_STAGES=2): enable=1 with an ideal div4 input -> edge_strobe every 4 cycles, 2+1 cycles after input rise. locked=1 one cycle after the 9th edge (1 search edge + 8 good). phase is constant. clk_regen is 2 high / 2 low and rises the cycle after each edge_strobe.
- Glitch in LOCKING: shorten one period to 3 cycles after 5 good edges -> one period_err, err_cnt=1, good_cnt restarts; locked after 8 further good edges.
- Loss of lock (LOSS_CNT=2): in LOCKED, two consecutive 5-cycle periods -> two period_err, err_cnt+=2, locked drops; clk_regen returns to 1. One bad period followed by a good one -> lock kept.
- Timeout: stop the input at 0 while LOCKED -> period_err when ivl reaches 8, state goes to SEARCH, locked=0. Restart the input -> relock after 9 edges.
- Saturation/reset: force 300 errors -> err_cnt holds 255. Assert resetb mid-lock -> all outputs clear asynchronously and clk_regen=1.
